decade_tick_scheduler: RTL and testbench

Synchronous replacement for the rippled decade clock chain. One prescaler plus six decade counters, all on the system clock, produce single-cycle rate strobes from 1 MHz down to 1 Hz (no derived clocks). NUM_CH independent channels are each configured over a valid/ready port to a decade rate. Each channel emits a one-cycle tick enable at that rate. Rate changes are glitch-free: a channel never emits a short period.

---
 rtl/decade_tick_scheduler_pkg.sv | 28 ++
 rtl/decade_tick_scheduler_if.sv | 26 ++
 rtl/decade_tick_scheduler_decade_counter.sv | 26 ++
 rtl/decade_tick_scheduler.sv | 136 +++++++++++++
 tb/tb_decade_tick_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/decade_tick_scheduler_pkg.sv
// Shared definitions for the decade tick scheduler: rate codes, channel
// state encoding and decade modulus.
package tick_sched_pkg;

    localparam logic [2:0] RATE_1HZ   = 3'd0;
    localparam logic [2:0] RATE_10HZ  = 3'd1;
    localparam logic [2:0] RATE_100HZ = 3'd2;
    localparam logic [2:0] RATE_1KHZ  = 3'd3;
    localparam logic [2:0] RATE_10KHZ = 3'd4;
    localparam logic [2:0] RATE_100KHZ = 3'd5;
    localparam logic [2:0] RATE_1MHZ  = 3'd6;
    localparam logic [2:0] RATE_RSVD  = 3'd7;

    localparam int unsigned DECADE_MOD  = 10;
    localparam int unsigned NUM_DECADES = 6;

    typedef enum logic [1:0] {
        CH_IDLE    = 2'd0,
        CH_PENDING = 2'd1,
        CH_RUN     = 2'd2
    } ch_state_e;

    // True for codes that select an actual strobe rate.
    function automatic logic rate_is_valid(input logic [2:0] rate);
        return rate != RATE_RSVD;
    endfunction

endpackage

// File: rtl/decade_tick_scheduler_if.sv
// Configuration port of the decade tick scheduler (valid/ready handshake).
interface decade_tick_scheduler_if #(
    parameter int unsigned CH_W = 2
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [2:0]      cfg_rate;
    logic            cfg_en;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_rate,
        output cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_rate,
        input  cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/decade_tick_scheduler_decade_counter.sv
// Mod-10 counter stage: advances on each enable pulse and emits a carry
// strobe in the same cycle as the 9->0 wrap.
module decade_counter
    import tick_sched_pkg::*;
(
    input  logic sys_clock,
    input  logic reset,
    input  logic en,
    output logic carry
);
    localparam logic [3:0] LAST = 4'(DECADE_MOD - 1);

    logic [3:0] count;

    // Count enable pulses, wrapping at the decade boundary.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 4'd1;
        end
    end

    assign carry = en & (count == LAST);

endmodule

// File: rtl/decade_tick_scheduler.sv
// Decade tick scheduler: a prescaler and six chained decade counters produce
// single-cycle strobes from 1 MHz (bit 6) down to 1 Hz (bit 0); NUM_CH
// channels each emit a tick enable at a configured decade rate.
// Optional build macro TICK_SCHED_SYNC_START_EN: pending channels start on
// the 1 Hz boundary instead of their own rate boundary.
module decade_tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int unsigned SYS_DIV = 50,
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned CH_W    = 2
) (
    input  logic                 sys_clock,
    input  logic                 reset,
    decade_tick_scheduler_if.slave cfg,
    output logic [6:0]           strobe,
    output logic [NUM_CH-1:0]    tick_out,
    output logic [NUM_CH-1:0]    ch_active,
    output logic                 cfg_err
);
    localparam int unsigned PRE_W = (SYS_DIV > 2) ? $clog2(SYS_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SYS_DIV - 1);

    logic [PRE_W-1:0] pre_count;
    logic [7:0]       strobe_ext;
    logic             accept;
    logic             err_d;

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [2:0]       rate_q  [NUM_CH];
    logic [2:0]       rate_d  [NUM_CH];
    logic [NUM_CH-1:0] ch_hit;
    logic [NUM_CH-1:0] boundary;
    logic [NUM_CH-1:0] tick_d;

    // Prescaler: wraps every SYS_DIV cycles to form the 1 MHz strobe.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            pre_count <= '0;
        end else if (pre_count == PRE_LAST) begin
            pre_count <= '0;
        end else begin
            pre_count <= pre_count + 1'b1;
        end
    end

    assign strobe[6] = (pre_count == PRE_LAST);

    for (genvar k = 0; k < NUM_DECADES; k++) begin : g_decade
        decade_counter u_decade (
            .sys_clock (sys_clock),
            .reset     (reset),
            .en        (strobe[k+1]),
            .carry     (strobe[k])
        );
    end

    // Code 7 reads as a permanently low strobe.
    assign strobe_ext = {1'b0, strobe};

    // Handshake: stall only while the addressed channel waits for its boundary.
    always_comb begin
        cfg.cfg_ready = ~reset;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (cfg.cfg_ch == CH_W'(c) && state_q[c] == CH_PENDING) begin
                cfg.cfg_ready = 1'b0;
            end
        end
    end

    assign accept = cfg.cfg_valid & cfg.cfg_ready;

    // Decode which channel the accepted config targets and its start boundary.
    always_comb begin
        ch_hit   = '0;
        boundary = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_hit[c] = accept && (cfg.cfg_ch == CH_W'(c));
`ifdef TICK_SCHED_SYNC_START_EN
            boundary[c] = strobe[0];
`else
            boundary[c] = strobe_ext[rate_q[c]];
`endif
        end
    end

    // Channel next state: a config always overrides a coincident boundary.
    always_comb begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            rate_d[c]  = rate_q[c];
            if (ch_hit[c]) begin
                if (cfg.cfg_en && rate_is_valid(cfg.cfg_rate)) begin
                    state_d[c] = CH_PENDING;
                    rate_d[c]  = cfg.cfg_rate;
                end else begin
                    state_d[c] = CH_IDLE;
                end
            end else if (state_q[c] == CH_PENDING && boundary[c]) begin
                state_d[c] = CH_RUN;
            end
        end
    end

    // Channel outputs: ticks only from RUN, dropped when a config lands.
    always_comb begin
        tick_d    = '0;
        ch_active = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            ch_active[c] = (state_q[c] == CH_RUN);
            tick_d[c]    = (state_q[c] == CH_RUN) && strobe_ext[rate_q[c]] && !ch_hit[c];
        end
        err_d = cfg_err | (accept & ~rate_is_valid(cfg.cfg_rate));
    end

    // State register for channels, tick outputs and the sticky error flag.
    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= CH_IDLE;
                rate_q[c]  <= '0;
            end
            tick_out <= '0;
            cfg_err  <= 1'b0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                rate_q[c]  <= rate_d[c];
            end
            tick_out <= tick_d;
            cfg_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_decade_tick_scheduler.sv
// Scoreboard bench for decade_tick_scheduler (SYS_DIV=2). Expected tick
// cycles are computed from rate periods and pushed per channel when a
// config is accepted; a negedge monitor pops and compares.
// Honours TICK_SCHED_SYNC_START_EN the same way as the design.
module tb_decade_tick_scheduler;
    localparam int unsigned SYS_DIV = 2;
    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned CH_W    = 2;
    localparam longint      HORIZON = 12000;

    logic              sys_clock = 1'b0;
    logic              reset     = 1'b1;
    logic [6:0]        strobe;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] ch_active;
    logic              cfg_err;

    decade_tick_scheduler_if #(.CH_W(CH_W)) cfg_if ();

    decade_tick_scheduler #(
        .SYS_DIV (SYS_DIV),
        .NUM_CH  (NUM_CH),
        .CH_W    (CH_W)
    ) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .cfg       (cfg_if),
        .strobe    (strobe),
        .tick_out  (tick_out),
        .ch_active (ch_active),
        .cfg_err   (cfg_err)
    );

    always #5 sys_clock = ~sys_clock;

    typedef struct {
        bit          en;
        int unsigned rate;
        longint      t;
        longint      b;
    } ch_rec_t;

    ch_rec_t rec [NUM_CH];
    bit      m_err;
    longint  expq [NUM_CH][$];
    longint  cyc = 0;
    int      checks = 0;
    int      fails  = 0;

    // cycle index since reset release (cycle 0 = first cycle after release)
    always @(posedge sys_clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic longint period(int unsigned r);
        longint p = SYS_DIV;
        for (int unsigned i = r; i < 6; i++) p = p * 10;
        return p;
    endfunction

    function automatic longint first_strobe_ge(int unsigned r, longint n0);
        longint p = period(r);
        return ((n0 + p) / p) * p - 1;
    endfunction

    function automatic bit m_pending(int c, longint n);
        return rec[c].en && n > rec[c].t && n <= rec[c].b;
    endfunction

    function automatic bit m_active(int c, longint n);
        return rec[c].en && n > rec[c].b;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < NUM_CH; c++) begin
            rec[c].en = 1'b0;
            rec[c].t  = 0;
            rec[c].b  = 0;
            expq[c].delete();
        end
        m_err = 1'b0;
    endtask

    task automatic apply(int c, int unsigned r, bit en, longint t);
        longint p;
        while (expq[c].size() > 0 && expq[c][$] >= t + 1) void'(expq[c].pop_back());
        if (r == 7) m_err = 1'b1;
        if (en && r <= 6) begin
            rec[c].en   = 1'b1;
            rec[c].rate = r;
            rec[c].t    = t;
`ifdef TICK_SCHED_SYNC_START_EN
            rec[c].b    = first_strobe_ge(0, t + 1);
`else
            rec[c].b    = first_strobe_ge(r, t + 1);
`endif
            p = period(r);
            for (longint m = rec[c].b + p; m + 1 <= HORIZON; m += p) expq[c].push_back(m + 1);
        end else begin
            rec[c].en = 1'b0;
        end
    endtask

    task automatic step(bit v, int c, int unsigned r, bit en);
        longint n;
        @(posedge sys_clock); #1;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = CH_W'(c);
        cfg_if.cfg_rate  = 3'(r);
        cfg_if.cfg_en    = en;
        n = cyc;
        @(negedge sys_clock); #1;
        if (v && !m_pending(c, n)) apply(c, r, en, n);
    endtask

    task automatic idle(int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic rand_steps(int cycles);
        int unsigned x;
        int unsigned r;
        for (int i = 0; i < cycles; i++) begin
            x = $urandom_range(0, 15);
            r = (x < 12) ? 3 + (x % 4) : ((x < 14) ? 7 : 2);
            step($urandom_range(0, 7) == 0, int'($urandom_range(0, NUM_CH - 1)), r,
                 $urandom_range(0, 7) != 0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge sys_clock); #1;
        reset = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        clear_model();
        @(posedge sys_clock); #1;
        reset = 1'b0;
    endtask

    // Monitor: compare every DUT output against the model each cycle.
    always @(negedge sys_clock) begin : monitor
        longint   n;
        logic [6:0] exp_s;
        bit       exp_t;
        if (reset) begin
            chk("rst_strobe", strobe, 0);
            chk("rst_tick", tick_out, 0);
            chk("rst_active", ch_active, 0);
            chk("rst_err", cfg_err, 0);
            chk("rst_ready", cfg_if.cfg_ready, 0);
        end else begin
            n = cyc;
            for (int unsigned r = 0; r < 7; r++) exp_s[r] = ((n + 1) % period(r)) == 0;
            chk("strobe", strobe, exp_s);
            for (int c = 0; c < NUM_CH; c++) begin
                while (expq[c].size() > 0 && expq[c][0] < n) begin
                    chk($sformatf("tick_miss[%0d]", c), 0, 1);
                    void'(expq[c].pop_front());
                end
                exp_t = (expq[c].size() > 0 && expq[c][0] == n);
                if (tick_out[c] || exp_t) begin
                    chk($sformatf("tick[%0d]", c), tick_out[c], exp_t);
                    if (exp_t) void'(expq[c].pop_front());
                end
                chk($sformatf("active[%0d]", c), ch_active[c], m_active(c, n));
            end
            chk("cfg_err", cfg_err, m_err);
            chk("cfg_ready", cfg_if.cfg_ready, !m_pending(int'(cfg_if.cfg_ch), n));
        end
    end

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_rate  = '0;
        cfg_if.cfg_en    = 1'b0;
        clear_model();
        repeat (2) @(posedge sys_clock);
        #1 reset = 1'b0;

        // free-running strobes only
        idle(25);
        // start three channels, then reconfigure ch1 mid-period
        step(1'b1, 0, 6, 1'b1);
        step(1'b1, 1, 5, 1'b1);
        step(1'b1, 3, 4, 1'b1);
        step(1'b1, 0, 5, 1'b1);
        idle(450);
        step(1'b1, 1, 4, 1'b1);
        idle(317);
        // reserved rate, then stop a running channel
        step(1'b1, 2, 7, 1'b1);
        idle(5);
        step(1'b1, 3, 4, 1'b0);
        idle(60);

        rand_steps(3000);
        // mid-run reset with channels active
        step(1'b1, 0, 6, 1'b1);
        step(1'b1, 1, 5, 1'b1);
        step(1'b1, 2, 6, 1'b1);
        idle(30);
        pulse_reset();
        idle(30);
        rand_steps(2000);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
